vecmat_add_tree: RTL

Parametrised, pipelined, saturating fixed-point adder tree that reduces a NUM_LANES-wide vector of signed products to one scalar per beat. It accumulates across multi-beat groups so dot products longer than the lane count can be reduced. A valid/ready handshake on both sides allows stalls. It sits between the vector multiplier array and the score/output buffers of the attention datapath.

---
 rtl/vecmat_add_tree_pkg.sv | 30 +++
 rtl/vecmat_add_tree_if.sv | 26 ++
 rtl/vecmat_add_tree_sat_add2.sv | 30 +++
 rtl/vecmat_add_tree.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vecmat_add_tree_pkg.sv
// Shared constants, types and elaboration helpers for the attention-path adder tree.
package vecmat_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam logic [DATA_WIDTH_DEF-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH_DEF-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HELD  = 2'd2
  } acc_state_t;

  function automatic int ceil_log2(input int value);
    int result;
    int pow;
    result = 32'sd0;
    pow    = 32'sd1;
    for (int i = 0; i < 31; i++) begin
      if (pow < value) begin
        result = result + 32'sd1;
      end else begin
        result = result;
      end
      pow = pow * 32'sd2;
    end
    return result;
  endfunction

endpackage

// File: rtl/vecmat_add_tree_if.sv
// Valid/ready beat input and group-result output bundle of the adder tree.
interface vecmat_add_tree_if #(
  parameter int DATA_WIDTH = vecmat_pkg::DATA_WIDTH_DEF,
  parameter int NUM_LANES  = 64,
  parameter int CNT_WIDTH  = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [CNT_WIDTH-1:0]            out_count;
  logic                            out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sat
  );
endinterface

// File: rtl/vecmat_add_tree_sat_add2.sv
// Two-input saturating signed adder; one instance per tree node and one for the accumulator.
module sat_add2
  import vecmat_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] c,
  output logic                  ovf
);
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0] sum_s;

  assign sum_s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
  assign ovf   = sum_s[DATA_WIDTH] ^ sum_s[DATA_WIDTH-1];

  // Clamp toward the sign of the true (DATA_WIDTH+1)-bit sum
  always_comb begin
    if (!ovf) begin
      c = sum_s[DATA_WIDTH-1:0];
    end else if (sum_s[DATA_WIDTH]) begin
      c = MIN_NEG;
    end else begin
      c = MAX_POS;
    end
  end
endmodule

// File: rtl/vecmat_add_tree.sv
// Pipelined saturating lane-reduction tree with multi-beat group accumulation.
module vecmat_add_tree
  import vecmat_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int NUM_LANES        = 64,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int CNT_WIDTH        = 8
) (
  input  logic              clk,
  input  logic              reset,
  vecmat_add_tree_if.slave  bus
);
  localparam int LOG2_LANES = ceil_log2(NUM_LANES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic en_s, first_s, out_valid_s;
  acc_state_t state_r, state_n;

  // Level 0 is the raw lane vector; level LOG2_LANES entry 0 is the beat sum.
  logic [DATA_WIDTH-1:0] node_s [0:LOG2_LANES][0:NUM_LANES-1];
  logic [LOG2_LANES:0]   lvl_v_s, lvl_last_s, lvl_sat_s;

  assign lvl_v_s[0]    = bus.in_valid;
  assign lvl_last_s[0] = bus.in_last;
  assign lvl_sat_s[0]  = 1'b0;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign node_s[0][k] = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar l = 1; l <= LOG2_LANES; l++) begin : g_lvl
    localparam int W = NUM_LANES >> l;
    logic [DATA_WIDTH-1:0] sum_s [0:W-1];
    logic [W-1:0]          ovf_s;
    logic                  sat_s;

    for (genvar k = 0; k < W; k++) begin : g_node
      sat_add2 #(.DATA_WIDTH(DATA_WIDTH)) u_add (
        .a   (node_s[l-1][2*k]),
        .b   (node_s[l-1][2*k+1]),
        .c   (sum_s[k]),
        .ovf (ovf_s[k])
      );
    end

    for (genvar k = W; k < NUM_LANES; k++) begin : g_pad
      assign node_s[l][k] = {DATA_WIDTH{1'b0}};
    end

    assign sat_s = lvl_sat_s[l-1] | (|ovf_s);

    if ((l % LEVELS_PER_STAGE == 0) || (l == LOG2_LANES)) begin : g_reg
      logic [DATA_WIDTH-1:0] data_r [0:W-1];
      logic                  v_r, last_r, sat_r;

      // Pipeline stage register; the whole tree freezes while the output is stalled
      always_ff @(posedge clk) begin
        if (!reset) begin
          v_r    <= 1'b0;
          last_r <= 1'b0;
          sat_r  <= 1'b0;
          for (int i = 0; i < W; i++) data_r[i] <= {DATA_WIDTH{1'b0}};
        end else if (en_s) begin
          v_r    <= lvl_v_s[l-1];
          last_r <= lvl_last_s[l-1];
          sat_r  <= sat_s;
          for (int i = 0; i < W; i++) data_r[i] <= sum_s[i];
        end
      end

      for (genvar k = 0; k < W; k++) begin : g_out
        assign node_s[l][k] = data_r[k];
      end
      assign lvl_v_s[l]    = v_r;
      assign lvl_last_s[l] = last_r;
      assign lvl_sat_s[l]  = sat_r;
    end else begin : g_comb
      for (genvar k = 0; k < W; k++) begin : g_out
        assign node_s[l][k] = sum_s[k];
      end
      assign lvl_v_s[l]    = lvl_v_s[l-1];
      assign lvl_last_s[l] = lvl_last_s[l-1];
      assign lvl_sat_s[l]  = sat_s;
    end
  end

  logic [DATA_WIDTH-1:0] tree_s;
  logic                  tree_v_s, tree_last_s, tree_sat_s;

  assign tree_s      = node_s[LOG2_LANES][0];
  assign tree_v_s    = lvl_v_s[LOG2_LANES];
  assign tree_last_s = lvl_last_s[LOG2_LANES];
  assign tree_sat_s  = lvl_sat_s[LOG2_LANES];

  // Accumulator-group state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_FIRST;
    end else begin
      state_r <= state_n;
    end
  end

  // HELD doubles as "first": a held result always ends a group.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_FIRST, ST_ACCUM: begin
        if (en_s && tree_v_s) begin
          state_n = tree_last_s ? ST_HELD : ST_ACCUM;
        end else begin
          state_n = state_r;
        end
      end
      ST_HELD: begin
        if (en_s && tree_v_s) begin
          state_n = tree_last_s ? ST_HELD : ST_ACCUM;
        end else if (en_s) begin
          state_n = ST_FIRST;
        end else begin
          state_n = ST_HELD;
        end
      end
      default: state_n = ST_FIRST;
    endcase
  end

  // State decode for the result-valid and group-start flags
  always_comb begin
    out_valid_s = 1'b0;
    first_s     = 1'b1;
    case (state_r)
      ST_FIRST: begin out_valid_s = 1'b0; first_s = 1'b1; end
      ST_ACCUM: begin out_valid_s = 1'b0; first_s = 1'b0; end
      ST_HELD:  begin out_valid_s = 1'b1; first_s = 1'b1; end
      default:  begin out_valid_s = 1'b0; first_s = 1'b1; end
    endcase
  end

  assign en_s          = ~out_valid_s | bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_s;

  logic [DATA_WIDTH-1:0] acc_r, acc_sum_s, acc_n_s, out_data_r;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_n_s, out_count_r;
  logic                  acc_sat_r, sat_n_s, acc_ovf_s, out_sat_r;

  sat_add2 #(.DATA_WIDTH(DATA_WIDTH)) u_acc_add (
    .a   (acc_r),
    .b   (tree_s),
    .c   (acc_sum_s),
    .ovf (acc_ovf_s)
  );

  // Post-update accumulator values for the beat leaving the tree
  always_comb begin
    acc_n_s = acc_r;
    cnt_n_s = cnt_r;
    sat_n_s = acc_sat_r;
    if (first_s) begin
      acc_n_s = tree_s;
      cnt_n_s = CNT_ONE;
      sat_n_s = tree_sat_s;
    end else begin
      acc_n_s = acc_sum_s;
      if (cnt_r == CNT_MAX) begin
        cnt_n_s = cnt_r;
      end else begin
        cnt_n_s = cnt_r + CNT_ONE;
      end
      sat_n_s = acc_sat_r | tree_sat_s | acc_ovf_s;
    end
  end

  // Accumulator and result registers; bubbles and stalls leave them untouched
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r       <= {DATA_WIDTH{1'b0}};
      cnt_r       <= {CNT_WIDTH{1'b0}};
      acc_sat_r   <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_count_r <= {CNT_WIDTH{1'b0}};
      out_sat_r   <= 1'b0;
    end else if (en_s && tree_v_s) begin
      acc_r     <= acc_n_s;
      cnt_r     <= cnt_n_s;
      acc_sat_r <= sat_n_s;
      if (tree_last_s) begin
        out_data_r  <= acc_n_s;
        out_count_r <= cnt_n_s;
        out_sat_r   <= sat_n_s;
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_count = out_count_r;
  assign bus.out_sat   = out_sat_r;
endmodule
